// File: rtl/xyz_pkg.sv
// Shared types for the field write scheduler: packed record layout, field
// select encoding and scheduler FSM states.
package xyz_pkg;

    typedef struct packed {
        logic       x;
        logic [3:0] y;
        logic       z;
        logic [1:0] w;
    } xyz_rec_t;

    typedef enum logic [1:0] {FLD_X, FLD_Y, FLD_Z, FLD_W} xyz_fld_e;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_COMMIT} xyz_state_e;

endpackage

// File: rtl/xyz_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, wrapping modulo NREQ. The pointer register is owned by the caller.
module xyz_rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_id,
    output logic                    gnt_vld
);

    localparam int IW = $clog2(NREQ);

    logic w_found;
    int   w_idx;

    always_comb begin
        w_found = 1'b0;
        gnt_id  = '0;
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(ptr) + k) % NREQ;
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                gnt_id  = IW'(w_idx);
            end
        end
    end

    assign gnt_vld = w_found;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
        assign gnt[gi] = w_found && (gnt_id == IW'(gi));
    end

endmodule

// File: rtl/xyz_field_write_scheduler.sv
// Serialises per-requester field writes into one packed record, with a
// programmable settle delay between grant and commit.
module xyz_field_write_scheduler
    import xyz_pkg::*;
#(
    parameter int         NREQ    = 4,
    parameter int         DELAY_W = 5,
    parameter logic [7:0] REC_RST = 8'h00
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [2*NREQ-1:0]       sel,
    input  logic [4*NREQ-1:0]       wdata,
    input  logic [DELAY_W-1:0]      delay_cfg,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic                    commit,
    output logic [$clog2(NREQ)-1:0] commit_id,
    output logic [7:0]              rec_q
);

    localparam int IW = $clog2(NREQ);

    xyz_state_e         r_state;
    xyz_state_e         w_state_next;
    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      r_id;
    logic [DELAY_W-1:0] r_cnt;
    xyz_fld_e           r_fld;
    logic [3:0]         r_wdata;
    xyz_rec_t           r_rec;

    logic [NREQ-1:0]    w_arb_gnt;
    logic [IW-1:0]      w_arb_id;
    logic               w_arb_vld;
    logic               w_grant;

    xyz_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (req),
        .ptr     (r_ptr),
        .gnt     (w_arb_gnt),
        .gnt_id  (w_arb_id),
        .gnt_vld (w_arb_vld)
    );

    assign w_grant = (r_state == ST_IDLE) && w_arb_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_vld) begin
                    w_state_next = (delay_cfg == '0) ? ST_COMMIT : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == DELAY_W'(1)) begin
                    w_state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Grant is combinational in IDLE; suppressed while reset is asserted.
    always_comb begin
        gnt    = '0;
        busy   = 1'b0;
        commit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!rst) begin
                    gnt = w_arb_gnt;
                end
            end
            ST_WAIT: busy = 1'b1;
            ST_COMMIT: begin
                busy   = 1'b1;
                commit = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_fld   <= FLD_X;
            r_wdata <= '0;
            r_id    <= '0;
            r_ptr   <= '0;
            r_rec   <= xyz_rec_t'(REC_RST);
        end else begin
            if (w_grant) begin
                r_cnt   <= delay_cfg;
                r_fld   <= xyz_fld_e'(sel[w_arb_id*2 +: 2]);
                r_wdata <= wdata[w_arb_id*4 +: 4];
                r_id    <= w_arb_id;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - DELAY_W'(1);
            end
            if (r_state == ST_COMMIT) begin
                r_ptr <= (r_id == IW'(NREQ-1)) ? '0 : r_id + IW'(1);
                case (r_fld)
                    FLD_X:   r_rec.x <= r_wdata[0];
                    FLD_Y:   r_rec.y <= r_wdata;
                    FLD_Z:   r_rec.z <= r_wdata[0];
                    FLD_W:   r_rec.w <= r_wdata[1:0];
                    default: ;
                endcase
            end
        end
    end

    assign commit_id = r_id;
    assign rec_q     = r_rec;

endmodule
